// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the round-robin add/subtract unit.
//   OP_ADD / OP_SUB : meaning of the per-channel req_sub bit
//   sat_clamp()     : signed saturation limit for a given width, used only
//                     when the design is built with ADDSUB_SAT_EN defined
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Returns the signed limit toward which an overflowed result clamps.
  // sign = 0 -> most positive value, sign = 1 -> most negative value.
  // The result is 64 bits wide; callers truncate it to their own width.
  function automatic logic [63:0] sat_clamp(input logic sign, input int unsigned width);
    logic [63:0] max_pos;
    max_pos = (64'd1 << (width - 1)) - 64'd1;
    return sign ? ~max_pos : max_pos;
  endfunction

endpackage

// File: rtl/addsub_rr_accum_if.sv
// Bus bundle for addsub_rr_accum.
//   req_valid/req_ready : per-channel request handshake
//   req_a/req_b         : operands, channel i at [i*WIDTH +: WIDTH]
//   req_sub             : 1 = A-B, 0 = A+B
//   req_acc             : 1 = take A from the channel accumulator
//   out_valid/out_ready : result handshake toward the single consumer
//   out_result/out_ch/out_carry/out_ovf : result payload
// master = requesters + consumer side, slave = the arithmetic unit.
interface addsub_rr_accum_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_ready;
  logic [NCH*WIDTH-1:0] req_a;
  logic [NCH*WIDTH-1:0] req_b;
  logic [NCH-1:0]       req_sub;
  logic [NCH-1:0]       req_acc;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [CHW-1:0]       out_ch;
  logic                 out_carry;
  logic                 out_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_acc, out_ready,
    input  req_ready, out_valid, out_result, out_ch, out_carry, out_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_acc, out_ready,
    output req_ready, out_valid, out_result, out_ch, out_carry, out_ovf
  );

endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter with its own priority pointer.
//   req       : request vector
//   advance   : a grant was consumed this cycle; move pointer past it
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : binary index of the granted requester
// The search starts at the pointer and wraps from N-1 back to 0.
module rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/addsub_rr_accum.sv
// Multi-channel add/subtract unit: NCH requesters share one WIDTH-bit adder
// through a round-robin arbiter; each channel keeps an accumulator that is
// overwritten by every result it produces.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : addsub_rr_accum_if slave (request and result handshakes)
// Subtraction is done as A + ~B + 1 on the same adder.
// Build option ADDSUB_SAT_EN: overflowed results clamp to the signed limit.
module addsub_rr_accum
  import addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int CHW   = $clog2(NCH)
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_rr_accum_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  logic [NCH-1:0]   grant;
  logic [CHW-1:0]   g;
  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] acc [NCH];

  logic             op_sub;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_raw;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] result;

  // The output register can take a new result when empty or draining.
  assign accept        = !bus.out_valid || bus.out_ready;
  assign bus.req_ready = (accept && rst_n) ? grant : '0;
  assign transfer      = |bus.req_ready;

  rr_arb #(.N(NCH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (g)
  );

  always_comb begin
    op_sub = bus.req_sub[g];
    a_op   = bus.req_acc[g] ? acc[g] : bus.req_a[g*WIDTH +: WIDTH];
    b_raw  = bus.req_b[g*WIDTH +: WIDTH];
    b_op   = (op_sub == OP_ADD) ? b_raw : ~b_raw;
    {carry, sum} = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, op_sub == OP_SUB};
    // Signed overflow: operands of equal sign produce a sum of the other sign.
    ovf    = (a_op[MSB] == b_op[MSB]) && (sum[MSB] != a_op[MSB]);
`ifdef ADDSUB_SAT_EN
    result = ovf ? WIDTH'(sat_clamp(a_op[MSB], WIDTH)) : sum;
`else
    result = sum;
`endif
  end

  // NOTE: the accumulator bank is reset explicitly because a channel's first
  // accumulate operation must see zero, not leftover contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_ch     <= '0;
      bus.out_carry  <= 1'b0;
      bus.out_ovf    <= 1'b0;
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (transfer) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= result;
      bus.out_ch     <= g;
      bus.out_carry  <= carry;
      bus.out_ovf    <= ovf;
      acc[g]         <= result;
    end else if (bus.out_ready) begin
      // Drain without zeroing the payload.
      bus.out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_rr_accum.sv
// Self-checking bench for addsub_rr_accum (WIDTH=8, NCH=4).
// A behavioural model predicts the grant, req_ready and the result of every
// accepted request; expected results are queued when the transfer happens
// and popped when the DUT presents them. Build with ADDSUB_SAT_EN to match a
// saturating DUT.
module tb_addsub_rr_accum;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  addsub_rr_accum_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  addsub_rr_accum #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int ch;
    int res;
    int carry;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_ptr;
  int   m_acc [NCH];
  bit   m_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.req_acc   = '0;
  endtask

  task automatic set_ch(input int ch, input int a, input int b, input bit sub, input bit acc);
    bus.req_valid[ch]               = 1'b1;
    bus.req_a[ch*WIDTH +: WIDTH]    = WIDTH'(a);
    bus.req_b[ch*WIDTH +: WIDTH]    = WIDTH'(b);
    bus.req_sub[ch]                 = sub;
    bus.req_acc[ch]                 = acc;
  endtask

  function automatic int to_s(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic exp_t model_op(input int ch, input int a, input int b, input bit sub);
    exp_t e;
    int   r;
    int   sr;
    if (sub) begin
      r       = a - b;
      e.carry = (a >= b) ? 1 : 0;
      sr      = to_s(a) - to_s(b);
    end else begin
      r       = a + b;
      e.carry = (r > 255) ? 1 : 0;
      sr      = to_s(a) + to_s(b);
    end
    e.ch  = ch;
    e.ovf = (sr > 127 || sr < -128) ? 1 : 0;
    e.res = r & 255;
`ifdef ADDSUB_SAT_EN
    if (e.ovf == 1) e.res = (sr > 127) ? 127 : 128;
`endif
    return e;
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit   found;
    int   g;
    bit   accept;
    bit   xfer;
    bit   rdy_q;
    logic [NCH-1:0] exp_rdy;
    exp_t e;
    #1;
    found = 1'b0;
    g     = 0;
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (m_ptr + i) % NCH;
      if (!found && bus.req_valid[k]) begin
        found = 1'b1;
        g     = k;
      end
    end
    rdy_q   = bus.out_ready;
    accept  = !m_ov || rdy_q;
    xfer    = accept && found;
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (xfer) begin
      int av;
      av = bus.req_acc[g] ? m_acc[g] : int'(bus.req_a[g*WIDTH +: WIDTH]);
      e  = model_op(g, av, int'(bus.req_b[g*WIDTH +: WIDTH]), bus.req_sub[g]);
      sb.push_back(e);
      m_acc[g] = e.res;
      m_ptr    = (g + 1) % NCH;
    end
    @(posedge clk);
    #1;
    if (xfer) begin
      e = sb.pop_front();
      check("out_valid", 32'(bus.out_valid), 1);
      check("out_ch",    32'(bus.out_ch),    e.ch);
      check("out_result",32'(bus.out_result),e.res);
      check("out_carry", 32'(bus.out_carry), e.carry);
      check("out_ovf",   32'(bus.out_ovf),   e.ovf);
      held = e;
      m_ov = 1'b1;
    end else if (m_ov && !rdy_q) begin
      check("hold_valid",  32'(bus.out_valid),  1);
      check("hold_ch",     32'(bus.out_ch),     held.ch);
      check("hold_result", 32'(bus.out_result), held.res);
      check("hold_carry",  32'(bus.out_carry),  held.carry);
      check("hold_ovf",    32'(bus.out_ovf),    held.ovf);
    end else begin
      m_ov = 1'b0;
      check("drain_valid", 32'(bus.out_valid), 0);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
    sb.delete();
  endtask

  // All channels request an accumulator read (acc + 0); every result must be 0.
  task automatic read_all_acc();
    clear_all();
    for (int i = 0; i < NCH; i++) set_ch(i, 8'hAA, 0, 1'b0, 1'b1);
    for (int i = 0; i < NCH; i++) step();
    clear_all();
  endtask

  initial begin
    model_reset();
    clear_all();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 8'h11, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_result",32'(bus.out_result),0);
    rst_n = 1'b1;

    // First grant goes to ch0 and all accumulators read back zero.
    read_all_acc();
    check("acc_ptr_wrap", 32'(m_ptr), 0);

    // Directed add/sub with flags.
    set_ch(0, 8'h05, 8'h03, 1'b0, 1'b0); step(); clear_all();
    set_ch(1, 8'h03, 8'h05, 1'b1, 1'b0); step(); clear_all();
    set_ch(1, 8'h80, 8'h01, 1'b1, 1'b0); step(); clear_all();
    set_ch(2, 8'hFF, 8'h01, 1'b0, 1'b0); step(); clear_all();
    set_ch(3, 8'h7F, 8'h7F, 1'b1, 1'b0); step(); clear_all();
    step();

    // Fairness: all channels valid continuously, random data.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NCH; i++)
        set_ch(i, $urandom_range(255), $urandom_range(255), 1'($urandom_range(1)), 1'($urandom_range(1)));
      step();
    end
    clear_all();
    step();

    // Backpressure with ch2 pending.
    set_ch(0, 8'h21, 8'h12, 1'b0, 1'b0); step(); clear_all();
    bus.out_ready = 1'b0;
    set_ch(2, 8'h40, 8'h08, 1'b1, 1'b0);
    repeat (3) step();
    bus.out_ready = 1'b1;
    step();
    clear_all();
    step();

    // Accumulate on ch3: load, then add to the running value.
    set_ch(3, 8'h70, 8'h00, 1'b0, 1'b0); step();
    set_ch(3, 8'h00, 8'h10, 1'b0, 1'b1); step();
    set_ch(3, 8'h00, 8'h01, 1'b1, 1'b1); step();
    clear_all();
    step();

    // Reset while a result is held.
    set_ch(1, 8'h33, 8'h44, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    step();
    for (int i = 0; i < NCH; i++) set_ch(i, 8'h01, 8'h01, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    check("midrst_out_result",32'(bus.out_result),0);
    check("midrst_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    model_reset();
    read_all_acc();
    step();

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
